// File: rtl/adc_serial_pkg.sv
// rtl/adc_serial_pkg.sv - shared types, defaults and framing helper for the ADC serial link
package adc_serial_pkg;

    // Defaults shared with the receive path
    localparam int ADC_DEFAULT_DATA_WIDTH   = 12;
    localparam int ADC_DEFAULT_NUM_CHANNELS = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tx_state_t;

    // Frame clock is high for the first half of the frame, low for the second half
    function automatic logic fco_level(input int counter, input int data_width);
        return (counter < (data_width / 2));
    endfunction

endpackage

// File: rtl/adc_frame_fifo.sv
// rtl/adc_frame_fifo.sv - single-clock first-word-fall-through frame FIFO
module adc_frame_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage array, not reset: contents are only visible through valid occupancy
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/adc_serial_tx.sv
// rtl/adc_serial_tx.sv - AD9228-style multi-lane serial frame transmitter with FCO
module adc_serial_tx
    import adc_serial_pkg::*;
#(
    parameter int NUM_CHANNELS = ADC_DEFAULT_NUM_CHANNELS,
    parameter int DATA_WIDTH   = ADC_DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 tx_en,
    input  logic                                 wr_valid,
    output logic                                 wr_ready,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   wr_data,
    output logic [NUM_CHANNELS-1:0]              dout,
    output logic                                 fco,
    output logic                                 busy,
    output logic                                 underrun,
    input  logic                                 underrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_level
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam int WW    = NUM_CHANNELS * DATA_WIDTH;

    tx_state_t                                  state_q, state_d;
    logic [CNT_W-1:0]                           cnt_q, cnt_d;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    shift_q, shift_d;
    logic [NUM_CHANNELS-1:0]                    dout_q, dout_d;
    logic                                       fco_q, fco_d;
    logic                                       underrun_q, underrun_d;

    logic          fifo_pop;
    logic [WW-1:0] fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;

    adc_frame_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (wr_valid),
        .wdata_i (wr_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign wr_ready = !fifo_full;
    assign dout     = dout_q;
    assign fco      = fco_q;
    assign busy     = (state_q == RUN);
    assign underrun = underrun_q;

    // State, bit counter, lane shifters and registered serial outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            dout_q     <= '0;
            fco_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            dout_q     <= dout_d;
            fco_q      <= fco_d;
            underrun_q <= underrun_d;
        end
    end

    // Framing sequencer: emits lane MSBs, decides at frame end whether to reload, pad with zeros or stop
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        dout_d     = '0;
        fco_d      = 1'b0;
        fifo_pop   = 1'b0;
        underrun_d = underrun_clr ? 1'b0 : underrun_q;

        case (state_q)
            IDLE: begin
                if (tx_en && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = RUN;
                    cnt_d    = '0;
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        shift_d[i] = fifo_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            RUN: begin
                fco_d = fco_level(int'(cnt_q), DATA_WIDTH);
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    dout_d[i]  = shift_q[i][DATA_WIDTH-1];
                    shift_d[i] = {shift_q[i][DATA_WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    cnt_d = '0;
                    if (tx_en && !fifo_empty) begin
                        fifo_pop = 1'b1;
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                            shift_d[i] = fifo_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end else if (tx_en) begin
                        // Keep framing alive with an all-zero word and flag the starvation
                        shift_d    = '0;
                        underrun_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_adc_serial_tx.sv
// tb/tb_adc_serial_tx.sv - self-checking bench for adc_serial_tx
module tb_adc_serial_tx;

    localparam int NC    = 4;
    localparam int DW    = 12;
    localparam int DEPTH = 16;

    typedef logic [NC*DW-1:0] word_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        tx_en;
    logic        wr_valid;
    logic        wr_ready;
    word_t       wr_data;
    logic [NC-1:0] dout;
    logic        fco;
    logic        busy;
    logic        underrun;
    logic        underrun_clr;
    logic [4:0]  fifo_level;

    int errors = 0;
    int checks = 0;

    adc_serial_tx #(
        .NUM_CHANNELS (NC),
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .tx_en        (tx_en),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .dout         (dout),
        .fco          (fco),
        .busy         (busy),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of words and a position inside the current frame
    word_t       m_q[$];
    bit          m_run;
    int          m_pos;
    word_t       m_word;
    bit          m_under;
    logic [NC-1:0] m_dout;
    bit          m_fco;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit acc;
        bit set_u;
        if (!rstn) begin
            m_q.delete();
            m_run = 0; m_pos = 0; m_word = '0; m_under = 0; m_dout = '0; m_fco = 0;
            return;
        end
        acc   = wr_valid && (m_q.size() != DEPTH);
        set_u = 0;
        m_dout = '0;
        m_fco  = 0;
        if (m_run) begin
            for (int i = 0; i < NC; i++) m_dout[i] = m_word[i*DW + DW - 1 - m_pos];
            m_fco = (m_pos < DW / 2);
        end
        if (!m_run) begin
            if (tx_en && m_q.size() > 0) begin
                m_word = m_q.pop_front();
                m_run  = 1;
                m_pos  = 0;
            end
        end else if (m_pos == DW - 1) begin
            if (tx_en) begin
                m_pos = 0;
                if (m_q.size() > 0) m_word = m_q.pop_front();
                else begin
                    m_word = '0;
                    set_u  = 1;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            m_pos++;
        end
        if (acc) m_q.push_back(wr_data);
        if (set_u) m_under = 1;
        else if (underrun_clr) m_under = 0;
    endtask

    task automatic check_model();
        chk("model_dout",     int'(dout),       int'(m_dout));
        chk("model_fco",      int'(fco),        int'(m_fco));
        chk("model_busy",     int'(busy),       int'(m_run));
        chk("model_underrun", int'(underrun),   int'(m_under));
        chk("model_level",    int'(fifo_level), m_q.size());
        chk("model_wr_ready", int'(wr_ready),   int'(m_q.size() != DEPTH));
    endtask

    // One clock: model advances with the DUT, then outputs are compared mid-cycle
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rstn = 1'b0; tx_en = 1'b0; wr_valid = 1'b0; underrun_clr = 1'b0; wr_data = '0;
        tick();
        rstn = 1'b1;
    endtask

    typedef struct {
        logic        valid;
        logic        txen;
        logic [11:0] d0;
        logic        e_dout0;
        logic        e_fco;
        logic        e_busy;
        int          e_level;
    } vec_t;

    vec_t        vt[15];
    logic [11:0] pat;
    logic [23:0] cap_d, cap_f;
    int          lvl;

    initial begin
        rstn = 1'b0; tx_en = 1'b0; wr_valid = 1'b0; underrun_clr = 1'b0; wr_data = '0;
        @(negedge clk);
        tick();
        chk("reset_dout", int'(dout), 0);
        chk("reset_fco", int'(fco), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_underrun", int'(underrun), 0);
        chk("reset_level", int'(fifo_level), 0);
        chk("reset_wr_ready", int'(wr_ready), 1);
        rstn = 1'b1;

        // Single frame 0xA5C on lane 0, as a vector table
        pat = 12'hA5C;
        vt[0] = '{1'b1, 1'b1, 12'hA5C, 1'b0, 1'b0, 1'b0, 1};
        vt[1] = '{1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b1, 0};
        for (int k = 2; k < 14; k++) begin
            vt[k] = '{1'b0, (k == 2), 12'h000, pat[13-k], (k < 8), (k < 13), 0};
        end
        vt[14] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 0};
        for (int k = 0; k < 15; k++) begin
            wr_valid = vt[k].valid;
            tx_en    = vt[k].txen;
            wr_data  = word_t'(vt[k].d0);
            tick();
            chk($sformatf("vec%0d_dout0", k), int'(dout[0]), int'(vt[k].e_dout0));
            chk($sformatf("vec%0d_fco", k),   int'(fco),     int'(vt[k].e_fco));
            chk($sformatf("vec%0d_busy", k),  int'(busy),    int'(vt[k].e_busy));
            chk($sformatf("vec%0d_level", k), int'(fifo_level), vt[k].e_level);
        end

        // Back-to-back frames 0xFFF then 0x001 on all lanes
        do_reset();
        tx_en = 1'b1; wr_valid = 1'b1; wr_data = {NC{12'hFFF}};
        tick();
        wr_data = {NC{12'h001}};
        tick();
        wr_valid = 1'b0;
        cap_d = '0; cap_f = '0;
        for (int k = 0; k < 24; k++) begin
            if (k == 14) tx_en = 1'b0;
            tick();
            cap_d = {cap_d[22:0], dout[3]};
            cap_f = {cap_f[22:0], fco};
        end
        chk("b2b_bits", int'(cap_d), 32'hFFF001);
        chk("b2b_fco", int'(cap_f), 32'hFC0FC0);
        chk("b2b_no_underrun", int'(underrun), 0);

        // Underrun: one word, tx_en held; clear mid-frame, then clear colliding with a new underrun
        do_reset();
        tx_en = 1'b1; wr_valid = 1'b1; wr_data = {NC{12'hABC}};
        tick();
        wr_valid = 1'b0;
        cap_d = '0; cap_f = '0;
        for (int k = 0; k < 40; k++) begin
            underrun_clr = (k == 18 || k == 24);
            if (k == 30) tx_en = 1'b0;
            tick();
            underrun_clr = 1'b0;
            if (k >= 13 && k <= 24) begin
                cap_d = {cap_d[22:0], |dout};
                cap_f = {cap_f[22:0], fco};
            end
            if (k == 11) chk("ur_before", int'(underrun), 0);
            if (k == 12) chk("ur_set", int'(underrun), 1);
            if (k == 18) chk("ur_cleared", int'(underrun), 0);
            if (k == 24) chk("ur_set_wins", int'(underrun), 1);
        end
        chk("ur_zero_frame", int'(cap_d[11:0]), 0);
        chk("ur_zero_fco", int'(cap_f[11:0]), 12'hFC0);
        chk("ur_idle_busy", int'(busy), 0);

        // Full FIFO with tx_en low, then first pop reopens wr_ready
        do_reset();
        for (int k = 0; k < 17; k++) begin
            wr_valid = 1'b1;
            wr_data  = word_t'({$urandom(), $urandom()});
            chk($sformatf("full_ready%0d", k), int'(wr_ready), int'(k < 16));
            tick();
        end
        wr_valid = 1'b0;
        chk("full_level", int'(fifo_level), 16);
        chk("full_ready_low", int'(wr_ready), 0);
        tx_en = 1'b1;
        tick();
        chk("full_ready_after_pop", int'(wr_ready), 1);
        chk("full_level_after_pop", int'(fifo_level), 15);

        // tx_en dropped at bit 5 of frame 0xABC: frame completes, remaining words kept
        do_reset();
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1'b1;
            wr_data  = (k == 0) ? word_t'(12'hABC) : word_t'({$urandom(), $urandom()});
            tick();
        end
        wr_valid = 1'b0;
        tx_en = 1'b1;
        tick();
        cap_d = '0;
        for (int k = 0; k < 12; k++) begin
            if (k == 5) tx_en = 1'b0;
            tick();
            cap_d = {cap_d[22:0], dout[0]};
        end
        chk("drop_bits", int'(cap_d[11:0]), 12'hABC);
        chk("drop_busy", int'(busy), 0);
        tick();
        chk("drop_dout", int'(dout), 0);
        chk("drop_fco", int'(fco), 0);
        chk("drop_level", int'(fifo_level), 2);

        // Reset at bit 7 with 3 words queued
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1;
            wr_data  = word_t'({$urandom(), $urandom()}) | word_t'(1);
            tick();
        end
        wr_valid = 1'b0;
        tx_en = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) tick();
        chk("rst_mid_level_before", int'(fifo_level), 3);
        rstn = 1'b0;
        tick();
        chk("rst_mid_dout", int'(dout), 0);
        chk("rst_mid_fco", int'(fco), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_level", int'(fifo_level), 0);
        chk("rst_mid_underrun", int'(underrun), 0);
        rstn = 1'b1;
        tick();
        chk("rst_mid_after_dout", int'(dout), 0);

        // Randomised traffic against the model
        tx_en = 1'b1;
        lvl = 2;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) lvl = $urandom_range(1, 4);
            wr_valid     = ($urandom_range(0, 4) < lvl);
            wr_data      = word_t'({$urandom(), $urandom()});
            underrun_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 59) == 0) tx_en = ~tx_en;
            rstn = ($urandom_range(0, 999) != 0);
            tick();
        end
        rstn = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_serial_tx.md
Name: adc_serial_tx

Overview:
- Serialising transmitter that emits AD9228-style per-channel frames: serial data lanes plus a frame clock (FCO), MSB first, one bit per clk (SDR).
- Used as the ADC-link emulator for board bring-up and loopback of the ADC receive path. Also usable as the serial transmit end for downstream DAC/test links.
- Parallel multi-channel samples enter through a valid/ready port into an internal frame FIFO.
- Single-ended outputs only. Diff conversion and DCO generation live outside this block; DCO is the inverted clk.

Parameters:
- NUM_CHANNELS, 4, number of serial data lanes
- DATA_WIDTH, 12, bits per sample per frame; must be even and at least 4
- FIFO_DEPTH, 16, frame FIFO entries; must be a power of 2

Ports:
- clk  in  1  bit clock, one serial bit per rising edge
- rstn  in  1  reset, synchronous, active-low
- tx_en  in  1  transmit enable
- wr_valid  in  1  sample word valid
- wr_ready  out  1  FIFO can accept a word
- wr_data  in  NUM_CHANNELS*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- dout  out  NUM_CHANNELS  serial data, one bit per lane
- fco  out  1  frame clock
- busy  out  1  high while in RUN
- underrun  out  1  sticky underrun flag
- underrun_clr  in  1  clears underrun
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rstn=0 at a clk edge): FIFO flushed, state=IDLE, bit counter=0, shift regs=0.
  - Outputs after reset: dout=0, fco=0, busy=0, underrun=0, fifo_level=0, wr_ready=1.
  - Reset mid-frame aborts the frame immediately; no partial bits are emitted afterwards.
- Write side:
  - wr_ready = (fifo_level != FIFO_DEPTH).
  - A write is accepted on an edge where wr_valid && wr_ready.
  - When full, wr_ready=0 even if a read occurs the same cycle; no bypass.
  - A simultaneous accepted write and FIFO pop leaves fifo_level unchanged.
- State IDLE: dout=0, fco=0, busy=0.
  - Transition to RUN on an edge with tx_en && fifo_level!=0.
  - On that edge: pop word into per-lane shift regs, bit counter=0.
- State RUN: all outputs registered; emitted bit is MSB of each lane's shift reg, shifting left each clk.
  - fco=1 for counter 0..DATA_WIDTH/2-1, fco=0 for DATA_WIDTH/2..DATA_WIDTH-1.
  - Bit counter increments 0..DATA_WIDTH-1, then wraps.
- Frame end (edge at counter=DATA_WIDTH-1):
  - tx_en && FIFO non-empty: pop next word, counter=0. No idle gap; frames are back-to-back.
  - tx_en && FIFO empty: load all-zero word, counter=0, set underrun. Framing (fco) continues unbroken.
  - !tx_en: go to IDLE, no pop.
- tx_en deassert mid-frame: the current frame completes fully; it is sampled only at the frame end.
- Latency: a word written into an empty FIFO while IDLE with tx_en=1 (accepted at edge N) is popped at edge N+1. Its MSB and fco=1 appear on outputs after edge N+2.
- underrun clearing: cleared by underrun_clr.
  - underrun_clr and a new underrun event on the same edge: set wins.
- fifo_level: registered; reflects pushes and pops of the previous edge.

Decomposition:
- Package adc_serial_pkg holds:
  - typedef enum {IDLE, RUN} tx_state_t
  - function fco_level(counter, DATA_WIDTH)
  - defaults for DATA_WIDTH and NUM_CHANNELS shared with the receive path
- One sub-module: adc_frame_fifo, a synchronous single-clock FIFO.
  - Parameters: width NUM_CHANNELS*DATA_WIDTH, depth FIFO_DEPTH.
  - Outputs: level, full, empty; first-word-fall-through read data.

Test Plan:
- Single frame: write ch0=0xA5C, other channels 0, tx_en=1.
  - dout[0] from edge N+2 = 1,0,1,0,0,1,0,1,1,1,0,0.
  - fco = 1 x6 then 0 x6; busy drops after frame if nothing follows and tx_en goes low.
- Back-to-back: write 0xFFF then 0x001 on all lanes, tx_en held.
  - 24 contiguous bits: twelve 1s, then eleven 0s, then a 1.
  - fco period exactly 12 clocks, no gap.
- Underrun: one word queued, tx_en held.
  - Second frame is all zeros with normal fco; underrun=1.
  - Pulse underrun_clr -> underrun=0 next edge unless another underrun occurs that same edge.
- Full FIFO: tx_en=0, 17 consecutive writes.
  - First 16 accepted, fifo_level=16, wr_ready=0 on the 17th.
  - Raise tx_en -> wr_ready=1 one edge after the first pop.
- tx_en drop mid-frame: deassert at bit 5 of frame 0xABC.
  - All 12 bits are still emitted; then IDLE with dout=0, fco=0; the FIFO keeps its remaining words.
- Reset mid-frame: assert rstn=0 at bit 7 with 3 words queued.
  - Next edge: dout=0, fco=0, busy=0, fifo_level=0, underrun=0.
